// File: rtl/clkgate_pkg.sv
// Shared types and limits for the clock-gating controller.
package clkgate_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } state_t;

  localparam int CLKGATE_CNT_W = 8;
  localparam int CLKGATE_STAT_W = 32;

  localparam int NREQ_MIN = 1;
  localparam int NREQ_MAX = 8;
  localparam int WAKE_CYCLES_MIN = 1;
  localparam int WAKE_CYCLES_MAX = 255;
  localparam int IDLE_CYCLES_MIN = 1;
  localparam int IDLE_CYCLES_MAX = 255;

endpackage

// File: rtl/clkgate_stat_cnt.sv
// Saturating cycle counter with a synchronous clear; clear wins over increment.
module clkgate_stat_cnt
  import clkgate_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      inc,
  input  logic                      clr,
  output logic [CLKGATE_STAT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CLKGATE_STAT_W'(1);
    end
  end

endmodule

// File: rtl/clkgate_ctrl.sv
// Clock-gating controller: OFF/WAKE/ON/IDLE FSM driving a gated buffer CE pin.
// Define CLKGATE_STATS_EN to build the gated-off cycle statistics counter.
module clkgate_ctrl
  import clkgate_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int WAKE_CYCLES = 4,
  parameter int IDLE_CYCLES = 16
) (
  input  logic                      i_clk,
  input  logic                      i_nrst,
  input  logic [NREQ-1:0]           i_req,
  input  logic                      i_busy,
  input  logic                      i_force_on,
  input  logic                      i_stat_clr,
  output logic                      o_clk_en,
  output logic [NREQ-1:0]           o_ack,
  output logic [1:0]                o_state,
  output logic [CLKGATE_STAT_W-1:0] o_off_cycles
);

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("clkgate_ctrl: NREQ=%0d out of range", NREQ);
  end
  if (WAKE_CYCLES < WAKE_CYCLES_MIN || WAKE_CYCLES > WAKE_CYCLES_MAX) begin : g_bad_wake
    $error("clkgate_ctrl: WAKE_CYCLES=%0d out of range", WAKE_CYCLES);
  end
  if (IDLE_CYCLES < IDLE_CYCLES_MIN || IDLE_CYCLES > IDLE_CYCLES_MAX) begin : g_bad_idle
    $error("clkgate_ctrl: IDLE_CYCLES=%0d out of range", IDLE_CYCLES);
  end

  localparam logic [CLKGATE_CNT_W-1:0] WAKE_LOAD = CLKGATE_CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CLKGATE_CNT_W-1:0] IDLE_LOAD = CLKGATE_CNT_W'(IDLE_CYCLES - 1);

  state_t                   state, next_state;
  logic [CLKGATE_CNT_W-1:0] cnt, cnt_next;
  logic                     need;
  logic                     clk_en_q;

  assign need = (|i_req) | i_busy | i_force_on;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
    next_state = state;
    cnt_next   = cnt;
    unique case (state)
      ST_OFF: begin
        if (need) begin
          next_state = ST_WAKE;
          cnt_next   = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (cnt == '0) next_state = ST_ON;
        else           cnt_next   = cnt - CLKGATE_CNT_W'(1);
      end
      ST_ON: begin
        if (!need) begin
          next_state = ST_IDLE;
          cnt_next   = IDLE_LOAD;
        end
      end
      ST_IDLE: begin
        // A returning need beats the expiring timer.
        if (need)            next_state = ST_ON;
        else if (cnt == '0)  next_state = ST_OFF;
        else                 cnt_next   = cnt - CLKGATE_CNT_W'(1);
      end
      default: next_state = ST_OFF;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    // NOTE: non-blocking for every flop so each samples the pre-edge values.
    if (!i_nrst) begin
      state    <= ST_OFF;
      cnt      <= '0;
      clk_en_q <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= cnt_next;
      clk_en_q <= (next_state != ST_OFF);
    end
  end

  // Enable comes straight from a flop so the buffer CE never sees a glitch.
  assign o_clk_en = clk_en_q;
  assign o_ack    = i_req & {NREQ{state == ST_ON}};
  assign o_state  = state;

`ifdef CLKGATE_STATS_EN
  clkgate_stat_cnt u_stat_cnt (
    .clk   (i_clk),
    .rst_n (i_nrst),
    .inc   (state == ST_OFF),
    .clr   (i_stat_clr),
    .count (o_off_cycles)
  );
`else
  logic stat_clr_unused;
  assign stat_clr_unused = i_stat_clr;
  assign o_off_cycles    = '0;
`endif

endmodule
